// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
//   Shared constants for the coprocessor-0 exception/interrupt controller:
//   register indices, SR/Cause field positions, exception codes and the EPC
//   helper used on exception entry.
//   Optional feature macro used by the including RTL: CP0_TIMER_EN.
// -----------------------------------------------------------------------------
package cp0_pkg;

    // mfc0/mtc0 register indices (rd field)
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // Field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int CAUSE_BD = 31;
    localparam int IM_BASE  = 10;   // SR.IM and Cause.IP share this base
    localparam int EXC_LSB  = 2;    // ExcCode occupies [6:2]

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Restart address for the faulting instruction: a delay-slot instruction
    // restarts at its branch. Arithmetic wraps modulo 2^32.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        logic [31:0] t;
        t = bd ? (pc - 32'd4) : pc;
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//   Count/Compare timer. Only instantiated when CP0_TIMER_EN is defined.
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   asynchronous active-low reset
//     count_we    in   load Count from wdata (suppresses the increment)
//     compare_we  in   load Compare from wdata (clears tmr_pend)
//     wdata       in   32-bit mtc0 data
//     count       out  current Count
//     compare     out  current Compare
//     tmr_pend    out  sticky timer interrupt pending
// -----------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        tmr_pend
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            compare  <= '0;
            tmr_pend <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we) begin
                compare  <= wdata;
                tmr_pend <= 1'b0;
            end else if (count == compare && compare != '0) begin
                // Compare==0 is treated as "timer disarmed".
                tmr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
//   Coprocessor-0 exception/interrupt controller at the M stage. Holds SR,
//   Cause, EPC, PRId and (with CP0_TIMER_EN defined) Count/Compare. Raises
//   req combinationally to flush the pipeline and redirect to handler_pc.
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   asynchronous active-low reset
//     cp0_addr    in   mfc0/mtc0 register index
//     cp0_wdata   in   mtc0 data
//     cp0_we      in   mtc0 in M stage
//     eret        in   eret in M stage
//     pc          in   M-stage PC
//     bd          in   M-stage instruction sits in a delay slot
//     exc_code    in   accumulated exception code (0 = none)
//     hw_int      in   level interrupt lines
//     req         out  take exception/interrupt this cycle
//     handler_pc  out  handler vector
//     epc_out     out  current EPC for eret redirect
//     rdata       out  mfc0 read data (combinational on cp0_addr)
//   Macro: CP0_TIMER_EN adds the Count/Compare timer on interrupt bit HWINT_W-1.
// -----------------------------------------------------------------------------
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          HWINT_W      = 6,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h0000_0007
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    input  logic               cp0_we,
    input  logic               eret,
    input  logic [31:0]        pc,
    input  logic               bd,
    input  logic [4:0]         exc_code,
    input  logic [HWINT_W-1:0] hw_int,
    output logic               req,
    output logic [31:0]        handler_pc,
    output logic [31:0]        epc_out,
    output logic [31:0]        rdata
);

    logic [HWINT_W-1:0] sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [HWINT_W-1:0] cause_ip;
    logic [4:0]         cause_exc;
    logic [31:0]        epc;

    logic               tmr_bit;
    logic [HWINT_W-1:0] tmr_vec;
    logic [HWINT_W-1:0] ip;
    logic               int_req;
    logic               exc_req;
    logic               wr_ok;

    // req wins over eret, eret wins over mtc0: a discarded mtc0 must not
    // reach any register, including the timer.
    assign wr_ok = cp0_we & ~req & ~eret;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_ok && cp0_addr == CP0_COUNT),
        .compare_we (wr_ok && cp0_addr == CP0_COMPARE),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .tmr_pend   (tmr_bit)
    );
`else
    assign tmr_bit = 1'b0;
`endif

    always_comb begin
        tmr_vec = '0;
        tmr_vec[HWINT_W-1] = tmr_bit;
    end

    assign ip      = hw_int | tmr_vec;
    assign int_req = (|(ip & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_code != 5'd0) & ~sr_exl;
    // Gated by reset so req is low for the whole time reset is held,
    // independent of what the pipeline is presenting.
    assign req     = reset & (int_req | exc_req);

    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= ip;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= int_req ? EXC_INT : exc_code;
                epc       <= epc_of(pc, bd);
            end else if (eret) begin
                sr_exl <= 1'b0;
            end else if (wr_ok) begin
                case (cp0_addr)
                    CP0_SR: begin
                        sr_im  <= cp0_wdata[IM_BASE +: HWINT_W];
                        sr_exl <= cp0_wdata[SR_EXL];
                        sr_ie  <= cp0_wdata[SR_IE];
                    end
                    CP0_EPC: epc <= {cp0_wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (cp0_addr)
            CP0_SR: begin
                rdata[IM_BASE +: HWINT_W] = sr_im;
                rdata[SR_EXL]             = sr_exl;
                rdata[SR_IE]              = sr_ie;
            end
            CP0_CAUSE: begin
                rdata[CAUSE_BD]              = cause_bd;
                rdata[IM_BASE +: HWINT_W]    = cause_ip;
                rdata[EXC_LSB +: 5]          = cause_exc;
            end
            CP0_EPC:     rdata = epc;
            CP0_PRID:    rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
//   Directed bench for cp0_exc_ctrl. Stimulus drives inputs just after a
//   rising edge and queues the hand-computed expectations for that cycle; a
//   monitor drains the queue on the falling edge and compares.
//   Honours CP0_TIMER_EN to pick the timer or no-timer vectors.
// -----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    localparam int HWINT_W = 6;

    logic               clk;
    logic               reset;
    logic [4:0]         cp0_addr;
    logic [31:0]        cp0_wdata;
    logic               cp0_we;
    logic               eret;
    logic [31:0]        pc;
    logic               bd;
    logic [4:0]         exc_code;
    logic [HWINT_W-1:0] hw_int;
    logic               req;
    logic [31:0]        handler_pc;
    logic [31:0]        epc_out;
    logic [31:0]        rdata;

    cp0_exc_ctrl #(.HWINT_W(HWINT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_we     (cp0_we),
        .eret       (eret),
        .pc         (pc),
        .bd         (bd),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .req        (req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out),
        .rdata      (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_REQ = 0, S_RD = 1, S_EPC = 2, S_HPC = 3;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic expect_val(input int sel, input logic [31:0] val, input string name);
        sb.push_back('{sel, val, name});
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string name);
        cp0_we   = 1'b0;
        cp0_addr = a;
        expect_val(S_RD, v, name);
    endtask

    // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                S_REQ:   act = {31'b0, req};
                S_RD:    act = rdata;
                S_EPC:   act = epc_out;
                default: act = handler_pc;
            endcase
            n_chk++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        end
    end

    initial begin
        logic [31:0] sr_exp;
        logic [31:0] cnt_after;

        reset = 1'b0; cp0_addr = '0; cp0_wdata = '0; cp0_we = 1'b0; eret = 1'b0;
        pc = '0; bd = 1'b0; exc_code = '0; hw_int = '0;
        cyc();

        // --- reset state ---
        hw_int = '1; exc_code = 5'd12;
        expect_val(S_REQ, 0, "req_in_reset");
        rd(5'd12, 32'h0, "sr_in_reset");
        cyc();
        reset = 1'b1; hw_int = '0; exc_code = '0;
        rd(5'd12, 32'h0, "sr_reset");
        expect_val(S_HPC, 32'h0000_4180, "handler_pc");
        cyc();
        rd(5'd13, 32'h0, "cause_reset");
        cyc();
        rd(5'd14, 32'h0, "epc_reset");
        expect_val(S_EPC, 32'h0, "epc_out_reset");
        cyc();
        hw_int = '1;
        rd(5'd15, 32'h7, "prid");
        expect_val(S_REQ, 0, "req_masked_all_int");
        cyc();
        hw_int = '0;
        rd(5'd13, 32'h0000_FC00, "cause_ip_sampled");
        expect_val(S_REQ, 0, "req_masked_idle");
        cyc();

        // --- interrupt entry ---
        mtc0(5'd12, 32'h0000_0401);
        expect_val(S_REQ, 0, "req_on_sr_write");
        cyc();
        hw_int = 6'b000001; pc = 32'h0000_1000; bd = 1'b0;
        rd(5'd12, 32'h0000_0401, "sr_written");
        expect_val(S_REQ, 1, "int_req_same_cycle");
        cyc();
        rd(5'd12, 32'h0000_0403, "sr_exl_set");
        expect_val(S_REQ, 0, "req_masked_by_exl");
        cyc();
        rd(5'd14, 32'h0000_1000, "epc_int");
        cyc();
        hw_int = '0;
        rd(5'd13, 32'h0000_0400, "cause_int");
        cyc();

        // --- exception in delay slot; same-cycle mtc0 discarded ---
        mtc0(5'd12, 32'h0);
        cyc();
        mtc0(5'd14, 32'h0000_5000);
        exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3008;
        expect_val(S_REQ, 1, "exc_req_ov");
        expect_val(S_RD, 32'h0000_1000, "epc_before_exc");
        cyc();
        exc_code = 5'd4; bd = 1'b0;
        rd(5'd13, 32'h8000_0030, "cause_ov_bd");
        expect_val(S_REQ, 0, "exc_masked_by_exl");
        cyc();
        exc_code = '0;
        rd(5'd14, 32'h0000_3004, "epc_bd_corrected");
        cyc();

        // --- eret ---
        eret = 1'b1;
        rd(5'd12, 32'h0000_0002, "sr_before_eret");
        expect_val(S_EPC, 32'h0000_3004, "epc_out_eret");
        expect_val(S_REQ, 0, "req_on_eret");
        cyc();
        eret = 1'b0;
        rd(5'd12, 32'h0, "sr_after_eret");
        cyc();

        // --- EPC wrap: pc=0 in delay slot ---
        exc_code = 5'd8; pc = 32'h0; bd = 1'b1;
        expect_val(S_REQ, 1, "exc_req_sys");
        cyc();
        exc_code = '0; bd = 1'b0;
        rd(5'd14, 32'hFFFF_FFFC, "epc_wrap");
        expect_val(S_EPC, 32'hFFFF_FFFC, "epc_out_wrap");
        cyc();
        rd(5'd13, 32'h8000_0020, "cause_sys_bd");
        cyc();

        // --- mtc0 clearing EXL with pending int: req only the next cycle ---
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0000_0401);
        expect_val(S_REQ, 0, "req_not_same_cycle");
        cyc();
        cp0_we = 1'b0; exc_code = 5'd12; pc = 32'h0000_2000;
        expect_val(S_REQ, 1, "req_next_cycle");
        cyc();
        exc_code = '0; hw_int = '0;
        rd(5'd13, 32'h0000_0400, "cause_int_priority");
        cyc();
        mtc0(5'd14, 32'h1234_5677);
        expect_val(S_RD, 32'h0000_2000, "epc_int_priority");
        expect_val(S_REQ, 0, "req_handler");
        cyc();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val(S_RD, 32'h0, "cause_before_write");
        cyc();
        rd(5'd14, 32'h1234_5674, "epc_mtc0_aligned");
        cyc();
        rd(5'd13, 32'h0, "cause_write_ignored");
        cyc();
        rd(5'd3, 32'h0, "unimpl_idx");
        cyc();
        eret = 1'b1;
        expect_val(S_REQ, 0, "req_eret2");
        cyc();
        eret = 1'b0;

`ifdef CP0_TIMER_EN
        // --- timer ---
        mtc0(5'd12, 32'h0000_8001);
        expect_val(S_REQ, 0, "req_tmr_setup");
        cyc();
        mtc0(5'd11, 32'd10);
        cyc();
        mtc0(5'd9, 32'd0);
        cyc();
        for (int i = 1; i <= 12; i++) begin
            rd(5'd9, 32'(i - 1), $sformatf("count_%0d", i - 1));
            expect_val(S_REQ, (i == 12) ? 32'd1 : 32'd0, $sformatf("tmr_req_c%0d", i));
            cyc();
        end
        rd(5'd13, 32'h0000_8000, "cause_tmr");
        cyc();
        mtc0(5'd11, 32'd0);
        expect_val(S_REQ, 0, "req_cmp_clear");
        cyc();
        cp0_we = 1'b0; eret = 1'b1;
        expect_val(S_REQ, 0, "req_eret_tmr");
        cyc();
        eret = 1'b0;
        rd(5'd11, 32'h0, "compare_zero");
        expect_val(S_REQ, 0, "tmr_pend_cleared");
        cyc();
        sr_exp    = 32'h0000_8003;
        cnt_after = 32'd1;
`else
        mtc0(5'd9, 32'd5);
        cyc();
        rd(5'd9, 32'h0, "count_absent");
        cyc();
        mtc0(5'd11, 32'd3);
        cyc();
        rd(5'd11, 32'h0, "compare_absent");
        cyc();
        sr_exp    = 32'h0000_0403;
        cnt_after = 32'd0;
`endif

        // --- reset during handler ---
        exc_code = 5'd10; pc = 32'h0000_4000; bd = 1'b0;
        expect_val(S_REQ, 1, "exc_req_ri");
        cyc();
        exc_code = '0;
        rd(5'd12, sr_exp, "sr_in_handler");
        cyc();
        reset = 1'b0; hw_int = '1; exc_code = 5'd5;
        #1;
        rd(5'd12, 32'h0, "sr_async_reset");
        expect_val(S_REQ, 0, "req_async_reset");
        cyc();
        reset = 1'b1; hw_int = '0; exc_code = '0;
        rd(5'd9, 32'h0, "count_restart");
        cyc();
        rd(5'd9, cnt_after, "count_after_release");
        cyc();
        rd(5'd12, 32'h0, "sr_after_release");
        expect_val(S_REQ, 0, "req_after_release");
        cyc();
        cyc();

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
